at_resp_parser: RTL and testbench
=================================

Name: at_resp_parser

Overview:
- Sits directly downstream of uart_rx and consumes its rx_done_tick/rx_data byte stream from the ESP32.
- Assembles CR/LF-terminated lines and classifies the final result line of an AT command as OK, ERROR/FAIL, or timeout.
- Returns a one-cycle result tick plus a held result code, so the AT-command FSM can sequence commands on real responses instead of blind delays.

Parameters:
- LINE_MAX, 16, line buffer depth in bytes (minimum 5).
- TIMEOUT_CYCLES, 100000000, clk cycles allowed from arm to result (1 s at 100 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx_done_tick  input  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_data  input  8  received byte.
- arm  input  1  one-cycle request to start waiting for a response.
- busy  output  1  high while waiting for a response.
- ok_tick  output  1  one-cycle pulse: OK line received while waiting.
- error_tick  output  1  one-cycle pulse: ERROR or FAIL line received while waiting.
- timeout_tick  output  1  one-cycle pulse: no result within TIMEOUT_CYCLES.
- prompt_tick  output  1  one-cycle pulse: '>' prompt received (see Optional Feature).
- last_resp  output  2  held result code: 00 none, 01 ok, 10 error, 11 timeout.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0, last_resp=00, state IDLE.
  - Line length 0, overflow flag clear, timer 0.
  - A reset asserted mid-line or mid-wait aborts everything; no tick is issued.
- Line assembly (runs in every state, on each rx_done_tick):
  - 0x0D: ignored.
  - 0x0A: terminates the line. The line is compared, then length and overflow flag are cleared. A line of length 0 is ignored.
  - Any other byte: stored at index len, len incremented. If len==LINE_MAX, the byte is dropped and the overflow flag is set.
  - An overflowed line never matches.
- Match rules (exact, case-sensitive, whole line):
  - "OK" (len 2) gives ok.
  - "ERROR" (len 5) or "FAIL" (len 4) gives error.
  - Anything else, e.g. echoed "AT" or "busy p...", is discarded.
- FSM states: IDLE, WAIT.
  - IDLE: arm -> WAIT. busy=1 from the next cycle; timer cleared; line buffer cleared (a partial line is discarded); last_resp=00.
    - If rx_done_tick coincides with arm, that byte becomes byte 0 of the new line.
    - Matches completed while in IDLE produce no tick and do not change last_resp.
  - WAIT: timer increments each cycle.
    - ok match -> ok_tick, last_resp=01, IDLE.
    - error match -> error_tick, last_resp=10, IDLE.
    - Timer reaches TIMEOUT_CYCLES -> timeout_tick, last_resp=11, IDLE.
    - arm while in WAIT is ignored.
- Latency:
  - A result tick is asserted exactly 1 clk after the rx_done_tick cycle carrying the 0x0A.
  - timeout_tick is asserted exactly TIMEOUT_CYCLES clks after the arm cycle.
  - busy deasserts in the same cycle as the tick.
- Simultaneous events:
  - A match and the timeout in the same cycle: the match wins.
  - Arm in the same cycle a line completes in IDLE: arm takes effect; the completed line is not reported.
- Widths: the timer is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
- Ticks are mutually exclusive; at most one tick is asserted per cycle.

Optional Feature:
- Macro: AT_PROMPT_DETECT_EN.
- Defined:
  - In WAIT, a 0x3E ('>') received at line length 0 ends the wait at once (CIPSEND data prompt), with no CR/LF required.
  - Output: prompt_tick 1 clk later, last_resp=01, state IDLE.
  - The byte is not stored in the line buffer.
  - In IDLE, '>' is treated as an ordinary character.
- Undefined:
  - prompt_tick is tied to 0.
  - '>' is always an ordinary character.

Test Plan:
- Basic OK:
  - Stimulus: arm, then bytes "AT\r\n\r\nOK\r\n".
  - Required: exactly one ok_tick, 1 clk after the final 0x0A; no tick on the echo line; last_resp=01; busy 1 -> 0.
- Error:
  - Stimulus: arm, then "ERROR\r\n"; later, arm, then "SEND FAIL\r\n" followed by "FAIL\r\n".
  - Required: error_tick for "ERROR", last_resp=10; only the exact "FAIL" line produces error_tick.
- Timeout (TIMEOUT_CYCLES=1000):
  - Stimulus: arm with no bytes; separately, arm with "OK\r\n" whose 0x0A lands so the match falls on cycle 1000.
  - Required: timeout_tick at arm+1000, last_resp=11; in the second case ok_tick and no timeout_tick.
- Overflow:
  - Stimulus: arm, then 20 bytes of "OKOKOKOKOKOKOKOKOKOK" followed by "\r\n", then "OK\r\n" (LINE_MAX=16).
  - Required: first line gives no tick; ok_tick only on the second line.
- Idle and reset:
  - Stimulus: "OK\r\n" with no arm; then arm, "OK" with reset pulsed low before "\r\n".
  - Required: no ticks at any point; all outputs 0 immediately on reset, without waiting for a clock edge.
- Prompt (AT_PROMPT_DETECT_EN defined):
  - Stimulus: arm, then "> ".
  - Required: prompt_tick 1 clk after the '>' byte, last_resp=01.
  - With the macro undefined: no tick until the timeout.

Source files
------------

// File: rtl/at_resp_parser.sv
`timescale 1ns/1ps
// at_resp_parser
// Consumes the uart_rx byte stream from the ESP32, assembles CR/LF-terminated
// lines and classifies the final result line of an AT command as OK,
// ERROR/FAIL or timeout. The AT-command sequencer arms the parser after it
// issues a command and waits for one of the result ticks.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   rx_done_tick  in   one-cycle strobe, rx_data valid in that cycle
//   rx_data       in   [7:0] received byte
//   arm           in   one-cycle request to start waiting for a response
//   busy          out  high while waiting for a response
//   ok_tick       out  one-cycle pulse, "OK" line received while waiting
//   error_tick    out  one-cycle pulse, "ERROR" or "FAIL" line received while waiting
//   timeout_tick  out  one-cycle pulse, no result within TIMEOUT_CYCLES of arm
//   prompt_tick   out  one-cycle pulse, '>' data prompt received while waiting
//   last_resp     out  [1:0] held result: 00 none, 01 ok, 10 error, 11 timeout
//
// Build option:
//   AT_PROMPT_DETECT_EN  when defined, a '>' at line length 0 while waiting
//                        ends the wait with prompt_tick (CIPSEND prompt).
//                        When undefined, prompt_tick is constant 0 and '>'
//                        is an ordinary character.
//
// States:
//   IDLE | not waiting; lines are still assembled but never reported
//   WAIT | armed; first OK / ERROR / FAIL / prompt / timeout ends the wait

module at_resp_parser #(
    parameter int LINE_MAX       = 16,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       arm,
    output logic       busy,
    output logic       ok_tick,
    output logic       error_tick,
    output logic       timeout_tick,
    output logic       prompt_tick,
    output logic [1:0] last_resp
);

    localparam int LEN_W     = $clog2(LINE_MAX + 1);
    localparam int TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    // Only the first five bytes can ever take part in a match ("ERROR" is
    // the longest keyword); later bytes just advance the length count.
    localparam int CMP_BYTES = 5;

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(LINE_MAX);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;
    // The arm edge is the first of the TIMEOUT_CYCLES clocks, so the tick is
    // registered when the in-WAIT count reaches TIMEOUT_CYCLES-1.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [1:0]       last_nxt;
    logic             ok_nxt, err_nxt, to_nxt, pr_nxt;
    logic             line_clr;

    logic [7:0]       line_buf [CMP_BYTES];
    logic [LEN_W-1:0] len, len_base, len_nxt;
    logic             ovf, ovf_nxt;
    logic             store_en;

    logic             is_cr, is_lf;
    logic             line_end, line_ok, line_err, prompt_hit;

    assign is_cr = (rx_data == CH_CR);
    assign is_lf = (rx_data == CH_LF);

    // A completed, non-empty, non-overflowed line is a match candidate.
    assign line_end = rx_done_tick && is_lf && (len != '0) && !ovf;

    assign line_ok  = line_end && (len == LEN_W'(2))
                      && (line_buf[0] == 8'h4F) && (line_buf[1] == 8'h4B);

    assign line_err = line_end && (
                         ((len == LEN_W'(5))
                          && (line_buf[0] == 8'h45) && (line_buf[1] == 8'h52)
                          && (line_buf[2] == 8'h52) && (line_buf[3] == 8'h4F)
                          && (line_buf[4] == 8'h52))
                      || ((len == LEN_W'(4))
                          && (line_buf[0] == 8'h46) && (line_buf[1] == 8'h41)
                          && (line_buf[2] == 8'h49) && (line_buf[3] == 8'h4C)));

`ifdef AT_PROMPT_DETECT_EN
    assign prompt_hit = (state == WAIT) && rx_done_tick
                        && (rx_data == 8'h3E) && (len == '0);
`else
    assign prompt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            timer        <= '0;
            last_resp    <= 2'b00;
            ok_tick      <= 1'b0;
            error_tick   <= 1'b0;
            timeout_tick <= 1'b0;
            prompt_tick  <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            last_resp    <= last_nxt;
            ok_tick      <= ok_nxt;
            error_tick   <= err_nxt;
            timeout_tick <= to_nxt;
            prompt_tick  <= pr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        last_nxt  = last_resp;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        to_nxt    = 1'b0;
        pr_nxt    = 1'b0;
        line_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = WAIT;
                    timer_nxt = '0;
                    last_nxt  = 2'b00;
                    line_clr  = 1'b1;
                end
            end
            WAIT: begin
                timer_nxt = (timer == TMR_MAX) ? timer : timer + 1'b1;
                // Priority: a line result beats a timeout landing on the same edge.
                if (line_ok) begin
                    ok_nxt    = 1'b1;
                    last_nxt  = 2'b01;
                    state_nxt = IDLE;
                end else if (line_err) begin
                    err_nxt   = 1'b1;
                    last_nxt  = 2'b10;
                    state_nxt = IDLE;
                end else if (prompt_hit) begin
                    pr_nxt    = 1'b1;
                    last_nxt  = 2'b01;
                    state_nxt = IDLE;
                end else if (timer_nxt >= TMR_LAST) begin
                    to_nxt    = 1'b1;
                    last_nxt  = 2'b11;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WAIT);

    // Line assembly. Arm discards any partial line first, so a byte arriving
    // on the arm cycle lands at index 0 of the fresh line.
    always_comb begin
        len_base = line_clr ? '0 : len;
        len_nxt  = len_base;
        ovf_nxt  = line_clr ? 1'b0 : ovf;
        store_en = 1'b0;
        if (rx_done_tick && !prompt_hit && !is_cr) begin
            if (is_lf) begin
                len_nxt = '0;
                ovf_nxt = 1'b0;
            end else if (len_base == LEN_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                store_en = 1'b1;
                len_nxt  = len_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len <= '0;
            ovf <= 1'b0;
            for (int i = 0; i < CMP_BYTES; i++) begin
                line_buf[i] <= 8'h00;
            end
        end else begin
            len <= len_nxt;
            ovf <= ovf_nxt;
            for (int i = 0; i < CMP_BYTES; i++) begin
                if (store_en && (len_base == LEN_W'(i))) begin
                    line_buf[i] <= rx_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_at_resp_parser.sv
`timescale 1ns/1ps
// Testbench for at_resp_parser (LINE_MAX=16, TIMEOUT_CYCLES=1000).
// Stimulus pushes the expected tick (kind, cycle, last_resp) into a queue;
// a negedge monitor pops and compares whenever any tick is high.

module tb_at_resp_parser;

    localparam int LINE_MAX = 16;
    localparam int TOC      = 1000;

    localparam int K_OK  = 1;
    localparam int K_ERR = 2;
    localparam int K_TO  = 3;
    localparam int K_PR  = 4;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       arm = 1'b0;
    logic       busy, ok_tick, error_tick, timeout_tick, prompt_tick;
    logic [1:0] last_resp;

    at_resp_parser #(
        .LINE_MAX       (LINE_MAX),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .arm          (arm),
        .busy         (busy),
        .ok_tick      (ok_tick),
        .error_tick   (error_tick),
        .timeout_tick (timeout_tick),
        .prompt_tick  (prompt_tick),
        .last_resp    (last_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] resp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t cyc=%0d)", name, act, req, $time, cyc);
        end
    endtask

    // Monitor / scoreboard
    exp_t e;
    int   n_ticks;
    int   k_seen;
    always @(negedge clk) begin
        n_ticks = $countones({ok_tick, error_tick, timeout_tick, prompt_tick});
        if (n_ticks > 1) check("tick_exclusive", n_ticks, 1);
        if (n_ticks != 0) begin
            k_seen = ok_tick ? K_OK : error_tick ? K_ERR : timeout_tick ? K_TO : K_PR;
            if (exp_q.size() == 0) begin
                check("unexpected_tick_kind", k_seen, 0);
            end else begin
                e = exp_q.pop_front();
                check("tick_kind", k_seen, e.kind);
                check("tick_cycle", cyc, e.cyc);
                check("tick_last_resp", last_resp, e.resp);
                check("tick_busy", busy, 0);
            end
        end
    end

    // All stimulus tasks start and end 1 ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_data      = b;
        tick();
        rx_done_tick = 1'b0;
    endtask

    // Sends body + CR + LF; the expected tick shows in the cycle after the LF.
    task automatic send_line(input string body, input int kind, input logic [1:0] resp);
        for (int i = 0; i < body.len(); i++) send_byte(body[i]);
        send_byte(CR);
        send_byte(LF);
        if (kind != 0) exp_q.push_back('{kind, cyc, resp});
    endtask

    task automatic do_arm(output int a);
        a   = cyc;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, ok_tick, error_tick, timeout_tick, prompt_tick, last_resp}, 0);
    endtask

    initial begin
        int a;

        // Reset state
        idle(3);
        check_all_zero("reset_outputs");
        reset = 1'b1;
        idle(2);

        // Basic OK with echo and blank line
        do_arm(a);
        check("arm_busy", busy, 1);
        check("arm_last_resp", last_resp, 2'b00);
        send_line("AT", 0, 2'b00);
        check("echo_still_busy", busy, 1);
        send_line("", 0, 2'b00);
        send_line("OK", K_OK, 2'b01);
        idle(2);
        check("ok_busy_low", busy, 0);
        check("ok_last_resp", last_resp, 2'b01);

        // ERROR, then SEND FAIL (no match) followed by FAIL
        do_arm(a);
        send_line("ERROR", K_ERR, 2'b10);
        idle(2);
        check("error_last_resp", last_resp, 2'b10);
        do_arm(a);
        send_line("SEND FAIL", 0, 2'b00);
        check("send_fail_still_busy", busy, 1);
        send_line("FAIL", K_ERR, 2'b10);
        idle(2);

        // Timeout; a second arm mid-wait must not restart the timer
        do_arm(a);
        exp_q.push_back('{K_TO, a + TOC, 2'b11});
        idle(500);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        while (cyc < a + TOC + 3) tick();
        check("timeout_last_resp", last_resp, 2'b11);
        check("timeout_busy_low", busy, 0);

        // OK whose LF is sampled on the same edge the timeout would fire
        do_arm(a);
        while (cyc < a + TOC - 4) tick();
        send_line("OK", 0, 2'b00);
        exp_q.push_back('{K_OK, a + TOC, 2'b01});
        idle(5);
        check("race_last_resp", last_resp, 2'b01);

        // Overflowed line never matches
        do_arm(a);
        send_line("OKOKOKOKOKOKOKOKOKOK", 0, 2'b00);
        check("overflow_still_busy", busy, 1);
        send_line("OK", K_OK, 2'b01);
        idle(2);

        // Byte coinciding with arm becomes byte 0 of the new line
        arm = 1'b1;
        rx_done_tick = 1'b1;
        rx_data = 8'h4F;
        tick();
        arm = 1'b0;
        rx_done_tick = 1'b0;
        send_line("K", K_OK, 2'b01);
        idle(2);

        // Line completing in IDLE on the arm cycle is not reported
        send_byte(8'h4F);
        send_byte(8'h4B);
        send_byte(CR);
        arm = 1'b1;
        rx_done_tick = 1'b1;
        rx_data = LF;
        tick();
        arm = 1'b0;
        rx_done_tick = 1'b0;
        check("arm_lf_busy", busy, 1);
        check("arm_lf_last_resp", last_resp, 2'b00);
        send_line("OK", K_OK, 2'b01);
        idle(2);

        // OK with no arm: no tick, last_resp held
        send_line("OK", 0, 2'b00);
        idle(2);
        check("idle_busy", busy, 0);
        check("idle_last_resp_held", last_resp, 2'b01);

        // Reset mid-line while waiting
        do_arm(a);
        send_byte(8'h4F);
        send_byte(8'h4B);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset_midwait");
        tick();
        reset = 1'b1;
        send_byte(CR);
        send_byte(LF);
        idle(3);
        check("after_reset_busy", busy, 0);
        check("after_reset_last_resp", last_resp, 2'b00);

        // Prompt
        do_arm(a);
`ifdef AT_PROMPT_DETECT_EN
        send_byte(8'h3E);
        exp_q.push_back('{K_PR, cyc, 2'b01});
        send_byte(8'h20);
        idle(3);
        check("prompt_last_resp", last_resp, 2'b01);
`else
        exp_q.push_back('{K_TO, a + TOC, 2'b11});
        send_byte(8'h3E);
        send_byte(8'h20);
        while (cyc < a + TOC + 3) tick();
        check("prompt_off_last_resp", last_resp, 2'b11);
`endif
        check("prompt_busy_low", busy, 0);

        // Asynchronous reset with a non-zero held result
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset_idle");
        tick();
        reset = 1'b1;
        idle(3);

        check("expected_ticks_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
